// File: rtl/infoframe_packet_builder.sv
// Runtime-programmable HDMI InfoFrame source: shadow payload, sequential checksum, atomic swap.
// Optional macro INFOFRAME_PACKET_BUILDER_FRAME_SYNC_EN defers the swap to the next frame_start pulse.
module infoframe_packet_builder #(
  parameter logic [6:0] TYPE    = 7'd2,
  parameter logic [7:0] VERSION = 8'd2,
  parameter logic [4:0] LENGTH  = 5'd13
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic         wr_ready,
  input  logic         commit,
  input  logic         frame_start,
  output logic         busy,
  output logic         updated,
  output logic         valid,
  output logic [23:0]  header,
  output logic [223:0] sub
);

  localparam logic [7:0] HB0  = {1'b1, TYPE};
  localparam logic [7:0] HB1  = VERSION;
  localparam logic [7:0] HB2  = {3'b000, LENGTH};
  localparam logic [7:0] HSUM = HB0 + HB1 + HB2;
  localparam logic [7:0] HCK  = 8'h00 - HSUM;
  localparam int         LEN  = int'(LENGTH);

  typedef enum logic [1:0] {IDLE, CALC, WAIT_SYNC, SWAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  shadow [1:27];
  logic [7:0]  active [0:27];
  logic [7:0]  acc;
  logic [4:0]  idx;
  logic [7:0]  shadow_rd;
  logic        pend;
  logic        swap_p0;
  logic        load;
  logic        calc_en;
  logic        swap_en;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [7:0] negate8(input logic [7:0] a);
    return 8'h00 - a;
  endfunction

  assign header = {HB2, HB1, HB0};

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (commit) state_nxt = CALC;
      CALC: begin
        if (idx == LENGTH) begin
`ifdef INFOFRAME_PACKET_BUILDER_FRAME_SYNC_EN
          state_nxt = WAIT_SYNC;
`else
          state_nxt = SWAP;
`endif
        end
      end
`ifdef INFOFRAME_PACKET_BUILDER_FRAME_SYNC_EN
      WAIT_SYNC: if (frame_start) state_nxt = SWAP;
`else
      WAIT_SYNC: state_nxt = IDLE;
`endif
      SWAP: state_nxt = (pend || commit) ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    wr_ready = (state == IDLE);
    calc_en  = (state == CALC);
    swap_en  = (state == SWAP);
    load     = ((state == IDLE) && commit) || ((state == SWAP) && (pend || commit));
  end

`ifndef INFOFRAME_PACKET_BUILDER_FRAME_SYNC_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  always_comb begin
    shadow_rd = 8'h00;
    for (int k = 1; k <= 27; k++)
      if (idx == 5'(k)) shadow_rd = shadow[k];
  end

  // Stage p0: checksum accumulate, shadow writes, swap; updated is the swap delayed one cycle
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= 8'h00;
      idx     <= 5'd0;
      pend    <= 1'b0;
      valid   <= 1'b0;
      swap_p0 <= 1'b0;
      updated <= 1'b0;
      for (int k = 1; k <= 27; k++) begin
        shadow[k] <= 8'h00;
        active[k] <= 8'h00;
      end
      active[0] <= HCK;
    end else begin
      if (wr_ready && wr_en)
        for (int k = 1; k <= 27; k++)
          if (wr_addr == 5'(k) && k <= LEN) shadow[k] <= wr_data;

      if (load) begin
        acc <= HSUM;
        idx <= 5'd1;
      end else if (calc_en) begin
        acc <= add8(acc, shadow_rd);
        idx <= idx + 5'd1;
      end

      if (swap_en)             pend <= 1'b0;
      else if (commit && busy) pend <= 1'b1;

      if (swap_en) begin
        for (int k = 1; k <= 27; k++)
          active[k] <= (k <= LEN) ? shadow[k] : 8'h00;
        active[0] <= negate8(acc);
        valid     <= 1'b1;
      end

      swap_p0 <= swap_en;
      updated <= swap_p0;
    end
  end

  for (genvar k = 0; k < 28; k++) begin : g_sub
    assign sub[k*8 +: 8] = active[k];
  end

endmodule
